// File: rtl/arith_decode_pkg.sv
// Shared types for the arithmetic-op decode stage.
// Holds the op enum, decoded-entry struct and RV32 opcode constants.
package arith_decode_pkg;

  typedef enum logic [3:0] {
    arithop_nop    = 4'd0,
    arithop_add    = 4'd1,
    arithop_sub    = 4'd2,
    arithop_inc    = 4'd3,
    arithop_mul    = 4'd4,
    arithop_mulh   = 4'd5,
    arithop_mulhsu = 4'd6,
    arithop_mulhu  = 4'd7,
    arithop_div    = 4'd8,
    arithop_divu   = 4'd9,
    arithop_rem    = 4'd10,
    arithop_remu   = 4'd11
  } rv32_arithop;

  typedef struct packed {
    rv32_arithop arithop;
    logic        invalid;
    logic        multicycle;
  } dec_t;

  localparam dec_t DEC_RESET = '{
    arithop:    arithop_nop,
    invalid:    1'b0,
    multicycle: 1'b0
  };

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic rv32_arithop muldiv_op(
    input logic [2:0] f3
  );
    rv32_arithop op;
    unique case (f3)
      3'b000:  op = arithop_mul;
      3'b001:  op = arithop_mulh;
      3'b010:  op = arithop_mulhsu;
      3'b011:  op = arithop_mulhu;
      3'b100:  op = arithop_div;
      3'b101:  op = arithop_divu;
      3'b110:  op = arithop_rem;
      default: op = arithop_remu;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/arith_decode_comb.sv
// Combinational RV32 instruction -> adder/multiplier op decode.
// Ports: i_inst in; o_arithop, o_invalid, o_multicycle out.
module arith_decode_comb
  import arith_decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0]  i_inst,
  output rv32_arithop  o_arithop,
  output logic         o_invalid,
  output logic         o_multicycle
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign opc = i_inst[6:0];
  assign f3  = i_inst[14:12];
  assign f7  = i_inst[31:25];

  // register and immediate fields do not affect the op class
  assign unused_bits = ^{i_inst[24:15], i_inst[11:7]};

  // defaults describe the invalid case: nop, no multicycle
  always_comb begin
    o_arithop    = arithop_nop;
    o_invalid    = 1'b1;
    o_multicycle = 1'b0;
    unique case (1'b1)
      (opc == OPC_OP): begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          unique case (f3)
            3'b000: begin
              o_arithop = i_inst[30] ? arithop_sub
                                     : arithop_add;
              o_invalid = 1'b0;
            end
            3'b010, 3'b011: begin
              if (!i_inst[30]) begin
                o_arithop = arithop_sub;
                o_invalid = 1'b0;
              end
            end
            default: ;
          endcase
        end else if (ENABLE_M && f7 == FUNCT7_MULDIV) begin
          o_arithop    = muldiv_op(f3);
          o_invalid    = 1'b0;
          o_multicycle = 1'b1;
        end
      end
      (opc == OPC_OP_IMM): begin
        unique case (f3)
          3'b000: begin
            o_arithop = arithop_add;
            o_invalid = 1'b0;
          end
          3'b010, 3'b011: begin
            o_arithop = arithop_sub;
            o_invalid = 1'b0;
          end
          default: ;
        endcase
      end
      (opc == OPC_LOAD || opc == OPC_STORE ||
       opc == OPC_AUIPC || opc == OPC_LUI): begin
        o_arithop = arithop_add;
        o_invalid = 1'b0;
      end
      (opc == OPC_BRANCH): begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          o_arithop = arithop_sub;
          o_invalid = 1'b0;
        end
      end
      (opc == OPC_JAL): begin
        o_arithop = arithop_inc;
        o_invalid = 1'b0;
      end
      (opc == OPC_JALR): begin
        if (f3 == 3'b000) begin
          o_arithop = arithop_inc;
          o_invalid = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arith_decode_stage.sv
// Registered decode stage with 2-entry skid buffer, flush and invalid counter.
// Ports: clk/rst/flush, valid/ready in and out, inst+tag in, decoded op+tag+count out.
module arith_decode_stage
  import arith_decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter int TAG_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_inst,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output rv32_arithop       o_arithop,
  output logic              o_invalid,
  output logic              o_multicycle,
  output logic [TAG_W-1:0]  o_tag,
  output logic [CNT_W-1:0]  o_invalid_count
);

  rv32_arithop      dec_op;
  logic             dec_inv;
  logic             dec_mc;
  dec_t             in_dec;
  dec_t             out_dec;
  dec_t             skid_dec;
  logic [TAG_W-1:0] out_tag;
  logic [TAG_W-1:0] skid_tag;
  logic             out_valid;
  logic             skid_valid;
  logic [CNT_W-1:0] cnt;
  logic             in_hs;
  logic             out_hs;

  arith_decode_comb #(
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .i_inst       (i_inst),
    .o_arithop    (dec_op),
    .o_invalid    (dec_inv),
    .o_multicycle (dec_mc)
  );

  always_comb begin
    in_dec            = DEC_RESET;
    in_dec.arithop    = dec_op;
    in_dec.invalid    = dec_inv;
    in_dec.multicycle = dec_mc;
  end

  // ready depends only on the skid register, never on i_ready
  assign o_ready = ~skid_valid;
  assign in_hs   = i_valid & ~skid_valid;
  assign out_hs  = out_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_dec    <= DEC_RESET;
      skid_dec   <= DEC_RESET;
      out_tag    <= '0;
      skid_tag   <= '0;
      cnt        <= '0;
    end else begin
      if (out_hs && out_dec.invalid && cnt != '1)
        cnt <= cnt + 1'b1;
      if (i_flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!out_valid || out_hs) begin
        // skid full implies no input handshake this cycle
        if (skid_valid) begin
          out_dec    <= skid_dec;
          out_tag    <= skid_tag;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (in_hs) begin
          out_dec   <= in_dec;
          out_tag   <= i_tag;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_hs) begin
        skid_dec   <= in_dec;
        skid_tag   <= i_tag;
        skid_valid <= 1'b1;
      end
    end
  end

  assign o_valid         = out_valid;
  assign o_arithop       = out_dec.arithop;
  assign o_invalid       = out_dec.invalid;
  assign o_multicycle    = out_dec.multicycle;
  assign o_tag           = out_tag;
  assign o_invalid_count = cnt;

endmodule
